// File: rtl/fp_div_pkg.sv
// Shared constants for the FP divider operand generator: LFSR taps, FSM state encoding,
// and IEEE-754 single-precision exponent field helpers.
package fp_div_pkg;

   // Feedback taps at bits 31, 21, 1 and 0.
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_GEN  = 2'd1;
   localparam state_t ST_HOLD = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   localparam int unsigned EXP_MSB     = 30;
   localparam int unsigned EXP_LSB     = 23;
   localparam logic [7:0]  EXP_ZERO    = 8'h00;
   localparam logic [7:0]  EXP_SPECIAL = 8'hFF;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], ^(s & LFSR_TAPS)};
   endfunction

   // Zero/denormal or inf/NaN operands are filtered out when the filter is enabled.
   function automatic logic is_special(input logic [31:0] x);
      logic [7:0] e;
      e = x[EXP_MSB:EXP_LSB];
      return (e == EXP_ZERO) || (e == EXP_SPECIAL);
   endfunction

endpackage

// File: rtl/fp_lfsr32.sv
// 32-bit Fibonacci LFSR with synchronous seed load and step enable.
module fp_lfsr32
   import fp_div_pkg::*;
(
   input  logic        clk,
   input  logic [31:0] seed,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] state
);

   logic [31:0] state_q;

   always_ff @(posedge clk) begin
      if (load) begin
         state_q <= seed;
      end else if (advance) begin
         state_q <= lfsr_step(state_q);
      end
   end

   assign state = state_q;

endmodule

// File: rtl/fp_operand_gen.sv
// Generates pseudo-random A/B single-precision operand pairs with a valid/ready handshake.
// Optional special-value filter enabled by defining FP_OPGEN_SPECIAL_FILTER_EN.
module fp_operand_gen
   import fp_div_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_SAMPLES = 20000,
   parameter logic [31:0] SEED_A      = 32'h3F800000,
   parameter logic [31:0] SEED_B      = 32'h40400000
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   output logic [XLEN-1:0]                  A,
   output logic [XLEN-1:0]                  B,
   output logic                             valid,
   input  logic                             ready,
   output logic                             busy,
   output logic                             done,
`ifdef FP_OPGEN_SPECIAL_FILTER_EN
   output logic [31:0]                      reject_cnt,
`endif
   output logic [$clog2(NUM_SAMPLES+1)-1:0] sample_cnt
);

   localparam int unsigned CW = $clog2(NUM_SAMPLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(NUM_SAMPLES);

   // An all-zero seed would lock the LFSR at zero forever.
   localparam logic [31:0] SEED_A_EFF = (SEED_A == 32'h0) ? 32'h1 : SEED_A;
   localparam logic [31:0] SEED_B_EFF = (SEED_B == 32'h0) ? 32'h1 : SEED_B;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   a_q, b_q;
   logic [CW-1:0]     cnt_q, cnt_inc;
   logic [31:0]       lfsr_a, lfsr_b;
   logic              accept, advance, run_start;

   fp_lfsr32 u_lfsr_a (
      .clk     (clk),
      .seed    (SEED_A_EFF),
      .load    (reset),
      .advance (advance),
      .state   (lfsr_a)
   );

   fp_lfsr32 u_lfsr_b (
      .clk     (clk),
      .seed    (SEED_B_EFF),
      .load    (reset),
      .advance (advance),
      .state   (lfsr_b)
   );

`ifdef FP_OPGEN_SPECIAL_FILTER_EN
   logic [31:0] rej_q;
   assign accept     = !(is_special(lfsr_a) || is_special(lfsr_b));
   assign reject_cnt = rej_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rej_q <= '0;
      end else if (run_start) begin
         rej_q <= '0;
      end else if (advance && !accept) begin
         rej_q <= rej_q + 32'd1;
      end
   end
`else
   assign accept = 1'b1;
`endif

   assign advance   = (state_q == ST_GEN);
   assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign cnt_inc   = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)  state_d = ST_GEN;
         ST_GEN:  if (accept) state_d = ST_HOLD;
         ST_HOLD: if (ready)  state_d = (cnt_inc == CNT_LAST) ? ST_DONE : ST_GEN;
         ST_DONE: if (start)  state_d = ST_GEN;
         default:             state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (run_start) begin
            cnt_q <= '0;
         end else if ((state_q == ST_HOLD) && ready) begin
            cnt_q <= cnt_inc;
         end
         if (advance && accept) begin
            a_q <= XLEN'(lfsr_a);
            b_q <= XLEN'(lfsr_b);
         end
      end
   end

   assign A          = a_q;
   assign B          = b_q;
   assign valid      = (state_q == ST_HOLD);
   assign busy       = (state_q == ST_GEN) || (state_q == ST_HOLD);
   assign done       = (state_q == ST_DONE);
   assign sample_cnt = cnt_q;

endmodule

// File: doc/fp_operand_gen.md
FP_OPERAND_GEN -- requirements
Module: fp_operand_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width (IEEE-754 single only).
REQ-002 SHALL have parameter NUM_SAMPLES, default 20000, operand pairs per run.
REQ-003 SHALL have parameter SEED_A, default 32'h3F800000, LFSR-A seed.
REQ-004 SHALL have parameter SEED_B, default 32'h40400000, LFSR-B seed.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, single-cycle run request.
REQ-008 SHALL have port A, output, XLEN, dividend operand.
REQ-009 SHALL have port B, output, XLEN, divisor operand.
REQ-010 SHALL have port valid, output, 1, A/B pair offered.
REQ-011 SHALL have port ready, input, 1, consumer (error_cal side) accepts pair.
REQ-012 SHALL have port busy, output, 1, run in progress.
REQ-013 SHALL have port done, output, 1, sticky run-complete flag.
REQ-014 SHALL have port sample_cnt, output, $clog2(NUM_SAMPLES+1), pairs accepted this run.

Function
REQ-015 SHALL implement FSM states IDLE, GEN, HOLD, DONE.
REQ-016 SHALL transition IDLE->GEN on start=1, clearing sample_cnt and done.
REQ-017 SHALL, in GEN, evaluate candidates equal to current LFSR-A/LFSR-B states, advance both LFSRs, and if accepted register them into A/B, set valid, go HOLD.
REQ-018 SHALL use per-LFSR step next = {s[30:0], s[31]^s[21]^s[1]^s[0]}; both LFSRs advance together every GEN cycle.
REQ-019 SHALL give first valid exactly 2 cycles after start sampled in IDLE (no rejections).
REQ-020 SHALL, in HOLD, keep A, B, valid stable while ready=0.
REQ-021 SHALL, on valid&ready, drop valid, increment sample_cnt, go DONE if new count equals NUM_SAMPLES else GEN.
REQ-022 SHALL hold done=1 in DONE until next start; start in DONE restarts as REQ-016 without reseeding LFSRs.
REQ-023 SHALL ignore start in GEN and HOLD.
REQ-024 SHALL assert busy in GEN and HOLD only.
REQ-025 SHALL substitute seed 32'h00000001 for a zero SEED_A/SEED_B (lockup avoidance).

Reset
REQ-026 SHALL on reset: state IDLE, A=0, B=0, valid=0, busy=0, done=0, sample_cnt=0, LFSRs reloaded from seeds.
REQ-027 SHALL let reset win over start/ready in the same cycle, including mid-HOLD (pending pair discarded).

Configuration
REQ-028 SHALL honour macro FP_OPGEN_SPECIAL_FILTER_EN.
REQ-029 SHALL with macro defined reject a candidate pair if either operand has exponent 8'h00 or 8'hFF; GEN stays in GEN, LFSRs advance, and a reject_cnt output (32-bit, cleared on start/reset) increments.
REQ-030 SHALL without macro accept every candidate and omit reject_cnt.

Structure
REQ-031 SHALL place LFSR tap constant, FSM state typedef, and exponent-field constants (EXP_MSB, EXP_LSB, EXP_ZERO, EXP_SPECIAL) in package fp_div_pkg.
REQ-032 SHALL instantiate LFSR as sub-module fp_lfsr32 (seed, load, advance, state), two instances.

Verification
REQ-033 SHALL cover: reset, start pulse, ready=1 -> first A=32'h3F800000, B=32'h40400000 valid 2 cycles after start.
REQ-034 SHALL cover: ready=0 for 10 cycles in HOLD -> A/B/valid unchanged, sample_cnt unchanged.
REQ-035 SHALL cover: NUM_SAMPLES=4, ready=1 -> exactly 4 handshakes, done=1, busy=0, sample_cnt=4.
REQ-036 SHALL cover: reset asserted in HOLD -> next cycle valid=0, state IDLE, outputs per REQ-026.
REQ-037 SHALL cover: macro defined, SEED_A=1 -> no emitted A/B with exponent 00/FF, reject_cnt>0 (first candidates 1, 3 rejected).
REQ-038 SHALL cover: start during busy -> ignored, sample_cnt continues monotonically.
